wb_dbg_master: RTL and testbench
================================

# wb_dbg_master

Wishbone bus initiator driven by a byte stream from a UART core. It occupies a spare master port of the `wb_conbus_top` interconnect. Host-side tooling uses it to peek and poke any slave (SRAM, BRAM, GPIO, farbborg) without CPU involvement. Each complete command frame produces one single-word Wishbone classic cycle followed by a response byte stream.

## Interface

Parameters:
- `wb_timeout`, 255: maximum cycles to wait for `wb_ack_i`/`wb_err_i` before aborting the cycle.
- `byte_timeout`, 50000: maximum idle cycles between bytes of one frame before the frame is discarded.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte.
- `rx_stb` in 1: one-cycle strobe; `rx_data` is valid. There is no backpressure.
- `tx_data` out 8: byte to transmit.
- `tx_wr` out 1: one-cycle write pulse to the UART transmitter.
- `tx_busy` in 1: transmitter occupied.
- `wb_adr_o` out 32, `wb_dat_o` out 32, `wb_sel_o` out 4, `wb_we_o` out 1, `wb_cyc_o` out 1, `wb_stb_o` out 1: master outputs.
- `wb_dat_i` in 32, `wb_ack_i` in 1, `wb_err_i` in 1: master inputs. `rty` is not used.
- `busy` out 1: high in every state except IDLE.
- `overrun` out 1: sticky flag, set when a byte is dropped. Cleared only by reset.

## Operation

Frame format (all multi-byte fields MSB first):
- `0x01` + 4 address bytes + 4 data bytes = write word, `sel=4'hF`.
- `0x02` + 4 address bytes = read word.
- Any other first byte: respond `0x15` (NAK) and return to IDLE.

Responses:
- Write ok: `0x06`.
- Read ok: 4 data bytes, MSB first.
- Any failure (`wb_err_i`, `wb_timeout` expiry): single `0x15`. A failed read sends no data bytes.

States:
- IDLE: on `rx_stb`, latch the command. Go to ADDR for `0x01`/`0x02`, otherwise TX with NAK.
- ADDR: shift 4 bytes into the address register (`adr <= {adr[23:0], rx_data}`). After the 4th byte, go to DATA for write or BUS for read.
- DATA: shift 4 bytes into the write-data register. After the 4th byte, go to BUS.
- BUS: drive `cyc=stb=1`. On `wb_ack_i`: latch `wb_dat_i` if reading, drop `cyc`/`stb` the same edge, go to TX with OK. On `wb_err_i` or timeout: drop `cyc`/`stb`, go to TX with NAK.
- TX: emit the response bytes one at a time, then return to IDLE.

Rules:
- A byte counter (2 bits) counts the field bytes. A response counter (2 bits) counts read bytes 3..0.
- Inter-byte timer: reloads on every `rx_stb` in ADDR/DATA. On expiry, return to IDLE silently; no response, no bus cycle.
- `rx_stb` while in BUS or TX: the byte is dropped and `overrun` is set.
- If `wb_ack_i` and `wb_err_i` are high in the same cycle, `wb_err_i` wins (NAK).
- `wb_adr_o` is presented as sent. Byte addressing is the host's responsibility; the block does not align or check the address.

## Timing

- Reset values: all Wishbone outputs 0, `tx_data=0`, `tx_wr=0`, `busy=0`, `overrun=0`, state IDLE. Counters and timers are cleared.
- Asserting `reset_n` mid-cycle drops `cyc`/`stb` immediately (asynchronously).
- `wb_cyc_o`/`wb_stb_o` rise on the clock edge following the `rx_stb` of the final frame byte.
- `wb_adr_o`, `wb_dat_o`, `wb_we_o` and `wb_sel_o` are stable for the whole time `cyc` is high.
- Bus latency: an ack sampled at edge N deasserts `cyc` and `stb` at edge N (registered). Minimum bus phase is 1 cycle.
- Timeout: if no ack/err arrives, `cyc` drops exactly `wb_timeout` cycles after it rose.
- TX sequencing: `tx_wr` pulses for exactly one cycle, only when `tx_busy=0`. The cycle after a pulse, `tx_busy` is ignored, because the UART raises it one cycle late. The first response byte is written no earlier than 1 cycle after the bus phase ends.
- Return to IDLE occurs the cycle after the last `tx_wr`. The next frame's first byte is accepted from that cycle onward.

## Test plan

- Write: bytes `01 00 00 70 02 DE AD BE EF`, slave acks after 2 cycles. Expect one cycle with `adr=0x00007002`, `dat=0xDEADBEEF`, `we=1`, `sel=F`, then `tx_data=0x06`.
- Read: `02 40 00 00 10`, slave returns `0x12345678`. Expect `we=0`, then tx bytes `12 34 56 78` in order, each `tx_wr` waiting out a 10-cycle `tx_busy`.
- Timeout: read to an unmapped slave with no ack. Expect `cyc` high for exactly `wb_timeout` cycles, then a single tx `0x15`.
- Error and collision: `wb_err_i` asserted, and separately `ack`+`err` in the same cycle. Expect NAK `0x15` in both cases.
- Framing: unknown byte `0x7F` gives NAK. A frame stalled after 2 address bytes for more than `byte_timeout` cycles produces no bus cycle; a following valid frame then completes correctly.
- Overrun and reset: a byte strobed during BUS sets `overrun=1` and the frame result is unaffected. `reset_n` pulsed during BUS clears `cyc`, `stb` and `overrun` immediately.

Source files
------------

// File: rtl/wb_dbg_master.sv
// rtl/wb_dbg_master.sv - UART byte-stream driven Wishbone debug initiator
module wb_dbg_master #(
    parameter int unsigned wb_timeout   = 255,
    parameter int unsigned byte_timeout = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_stb,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_TX
    } state_t;

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;
    localparam logic [7:0] RSP_OK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    state_t      r_state;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_adr;
    logic [31:0] r_wdat;
    logic        r_cyc;
    logic [1:0]  r_cnt;
    logic [31:0] r_byte_tmr;
    logic [31:0] r_bus_tmr;
    // Response bytes leave from the top of this register, MSB first.
    logic [31:0] r_shift;
    logic [1:0]  r_rsp_cnt;
    logic        r_last;
    // Set for the cycle after a tx_wr pulse, when the UART has not yet raised tx_busy.
    logic        r_gap;
    logic [7:0]  r_tx_data;
    logic        r_tx_wr;
    logic        r_overrun;

    wire         w_field_done = (r_cnt == 2'd3);
    wire         w_rx_drop    = rx_stb && ((r_state == S_BUS) || (r_state == S_TX));

    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_wdat;
    assign wb_sel_o = r_sel;
    assign wb_we_o  = r_we;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;
    assign tx_data  = r_tx_data;
    assign tx_wr    = r_tx_wr;
    assign busy     = (r_state != S_IDLE);
    assign overrun  = r_overrun;

    // Frame parser, bus cycle and response sequencer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_sel      <= 4'h0;
            r_adr      <= 32'h0;
            r_wdat     <= 32'h0;
            r_cyc      <= 1'b0;
            r_cnt      <= 2'd0;
            r_byte_tmr <= 32'h0;
            r_bus_tmr  <= 32'h0;
            r_shift    <= 32'h0;
            r_rsp_cnt  <= 2'd0;
            r_last     <= 1'b0;
            r_gap      <= 1'b0;
            r_tx_data  <= 8'h0;
            r_tx_wr    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_rx_drop) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (rx_stb) begin
                        r_cnt      <= 2'd0;
                        r_byte_tmr <= 32'h0;
                        if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                            r_we    <= (rx_data == CMD_WR);
                            r_sel   <= 4'hF;
                            r_state <= S_ADDR;
                        end else begin
                            r_shift   <= {RSP_NAK, 24'h0};
                            r_rsp_cnt <= 2'd0;
                            r_state   <= S_TX;
                        end
                    end
                end
                S_ADDR, S_DATA: begin
                    if (rx_stb) begin
                        r_byte_tmr <= 32'h0;
                        r_cnt      <= r_cnt + 2'd1;
                        if (r_state == S_ADDR) begin
                            r_adr <= {r_adr[23:0], rx_data};
                        end else begin
                            r_wdat <= {r_wdat[23:0], rx_data};
                        end
                        if (w_field_done) begin
                            if (r_state == S_ADDR && r_we) begin
                                r_state <= S_DATA;
                            end else begin
                                r_cyc     <= 1'b1;
                                r_bus_tmr <= 32'h0;
                                r_state   <= S_BUS;
                            end
                        end
                    end else if (r_byte_tmr == byte_timeout - 1) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_byte_tmr <= r_byte_tmr + 32'h1;
                    end
                end
                S_BUS: begin
                    // err has priority over a simultaneous ack.
                    if (wb_err_i) begin
                        r_cyc     <= 1'b0;
                        r_shift   <= {RSP_NAK, 24'h0};
                        r_rsp_cnt <= 2'd0;
                        r_state   <= S_TX;
                    end else if (wb_ack_i) begin
                        r_cyc   <= 1'b0;
                        r_state <= S_TX;
                        if (r_we) begin
                            r_shift   <= {RSP_OK, 24'h0};
                            r_rsp_cnt <= 2'd0;
                        end else begin
                            r_shift   <= wb_dat_i;
                            r_rsp_cnt <= 2'd3;
                        end
                    end else if (r_bus_tmr == wb_timeout - 1) begin
                        r_cyc     <= 1'b0;
                        r_shift   <= {RSP_NAK, 24'h0};
                        r_rsp_cnt <= 2'd0;
                        r_state   <= S_TX;
                    end else begin
                        r_bus_tmr <= r_bus_tmr + 32'h1;
                    end
                end
                S_TX: begin
                    if (r_gap) begin
                        r_gap   <= 1'b0;
                        r_tx_wr <= 1'b0;
                        if (r_last) begin
                            r_state <= S_IDLE;
                        end
                    end else if (!tx_busy) begin
                        r_tx_data <= r_shift[31:24];
                        r_shift   <= {r_shift[23:0], 8'h0};
                        r_tx_wr   <= 1'b1;
                        r_gap     <= 1'b1;
                        r_last    <= (r_rsp_cnt == 2'd0);
                        r_rsp_cnt <= r_rsp_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dbg_master.sv
// tb/tb_wb_dbg_master.sv - self-checking bench for wb_dbg_master
module tb_wb_dbg_master;

    localparam int WB_TO   = 16;
    localparam int BYTE_TO = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_stb = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy = 1'b0;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        busy, overrun;

    always #5 clk = ~clk;

    wb_dbg_master #(.wb_timeout(WB_TO), .byte_timeout(BYTE_TO)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_stb(rx_stb),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .busy(busy), .overrun(overrun)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Slave: mode 0 ack, 1 err, 2 ack+err together, 3 never answers.
    int          s_mode = 0;
    int          s_delay = 1;
    int          s_cnt = 0;
    logic [31:0] s_rdata = 32'h0;
    always @(negedge clk) begin
        if (wb_cyc_o && wb_stb_o) begin
            s_cnt    = s_cnt + 1;
            wb_ack_i = (s_cnt == s_delay) && (s_mode == 0 || s_mode == 2);
            wb_err_i = (s_cnt == s_delay) && (s_mode == 1 || s_mode == 2);
            wb_dat_i = wb_ack_i ? s_rdata : ~s_rdata;
        end else begin
            s_cnt    = 0;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
        end
    end

    // Bus monitor: counts cycles, captures the attributes, length and stability.
    logic        prev_cyc = 1'b0;
    int          n_bus = 0, cyc_len = 0, last_len = 0, unstable = 0, viol_bus = 0;
    logic [31:0] m_adr, m_dat;
    logic        m_we;
    logic [3:0]  m_sel;
    always @(negedge clk) begin
        if (wb_cyc_o !== wb_stb_o) viol_bus++;
        if (wb_cyc_o) begin
            if (!prev_cyc) begin
                n_bus++;
                cyc_len = 1;
                m_adr = wb_adr_o; m_dat = wb_dat_o; m_we = wb_we_o; m_sel = wb_sel_o;
            end else begin
                cyc_len++;
                if (wb_adr_o !== m_adr || wb_dat_o !== m_dat || wb_we_o !== m_we || wb_sel_o !== m_sel)
                    unstable++;
            end
        end else if (prev_cyc) begin
            last_len = cyc_len;
        end
        prev_cyc = wb_cyc_o;
    end

    // UART model: tx_busy rises one cycle after a pulse and holds busy_len cycles.
    logic [7:0] tx_q[$];
    int         busy_len = 3, b_cnt = 0, viol_tx = 0;
    bit         pend = 0, prev_wr = 0, u_prev_cyc = 0;
    always @(negedge clk) begin
        if (tx_wr) begin
            tx_q.push_back(tx_data);
            if (tx_busy) viol_tx++;
            if (prev_wr) viol_tx++;
            if (u_prev_cyc) viol_tx++;
        end
        if (b_cnt > 0) begin
            b_cnt--;
            if (b_cnt == 0) tx_busy = 1'b0;
        end
        if (pend) begin
            tx_busy = 1'b1;
            b_cnt = busy_len;
            pend = 0;
        end
        if (tx_wr) pend = 1;
        prev_wr = tx_wr;
        u_prev_cyc = wb_cyc_o;
    end

    logic [7:0] exp_q[$];

    // Reference: response bytes from the command and the slave's behaviour.
    task automatic expect_resp(input logic [7:0] cmd, input int mode, input logic [31:0] rd);
        exp_q.delete();
        if (cmd != 8'h01 && cmd != 8'h02) exp_q.push_back(8'h15);
        else if (mode != 0) exp_q.push_back(8'h15);
        else if (cmd == 8'h01) exp_q.push_back(8'h06);
        else for (int i = 3; i >= 0; i--) exp_q.push_back(8'((rd >> (8 * i)) % 256));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_stb = 1'b1;
        @(negedge clk);
        rx_stb = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            tick($urandom_range(0, 2));
            send_byte(8'((w >> (8 * i)) % 256));
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, {31'h0, busy}, 32'h0);
    endtask

    task automatic do_frame(input string tag, input logic [7:0] cmd, input logic [31:0] adr,
                            input logic [31:0] dat, input int mode, input int delay,
                            input logic [31:0] rd, input bit inject);
        int  nb0 = n_bus;
        int  v0 = viol_bus + viol_tx;
        int  u0 = unstable;
        bit  valid = (cmd == 8'h01 || cmd == 8'h02);
        s_mode = mode; s_delay = delay; s_rdata = rd;
        tx_q.delete();
        send_byte(cmd);
        if (valid) begin
            send_word(adr);
            if (cmd == 8'h01) send_word(dat);
            check({tag, "_cyc_rise"}, {31'h0, wb_cyc_o}, 32'h1);
        end
        if (inject) begin
            send_byte(8'h55);
            check({tag, "_overrun"}, {31'h0, overrun}, 32'h1);
        end
        wait_idle(tag);
        expect_resp(cmd, mode, rd);
        check({tag, "_nbus"}, n_bus - nb0, valid ? 1 : 0);
        if (valid) begin
            check({tag, "_adr"}, m_adr, adr);
            check({tag, "_we"}, {31'h0, m_we}, (cmd == 8'h01) ? 32'h1 : 32'h0);
            if (cmd == 8'h01) begin
                check({tag, "_dat"}, m_dat, dat);
                check({tag, "_sel"}, {28'h0, m_sel}, 32'hF);
            end
            check({tag, "_cyclen"}, last_len, (mode == 3) ? WB_TO : delay);
        end
        check({tag, "_txcount"}, tx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check({tag, "_txbyte"}, (i < tx_q.size()) ? {24'h0, tx_q[i]} : 32'hxxxxxxxx, {24'h0, exp_q[i]});
        check({tag, "_protocol"}, viol_bus + viol_tx - v0, 0);
        check({tag, "_stable"}, unstable - u0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  c;
        logic [31:0] a, d, r;
        int          nb0;

        tick(3);
        check("rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
        check("rst_stb", {31'h0, wb_stb_o}, 32'h0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_sel_we", {27'h0, wb_sel_o, wb_we_o}, 32'h0);
        check("rst_tx", {23'h0, tx_data, tx_wr}, 32'h0);
        check("rst_busy_ovr", {30'h0, busy, overrun}, 32'h0);
        reset_n = 1'b1;
        tick(2);

        do_frame("write", 8'h01, 32'h00007002, 32'hDEADBEEF, 0, 2, 32'h0, 0);
        busy_len = 10;
        do_frame("read", 8'h02, 32'h40000010, 32'h0, 0, 1, 32'h12345678, 0);
        busy_len = 3;
        do_frame("timeout", 8'h02, 32'hF0000000, 32'h0, 3, 1, 32'h0, 0);
        do_frame("err", 8'h01, 32'h00000100, 32'h11223344, 1, 2, 32'h0, 0);
        do_frame("collide", 8'h02, 32'h00000200, 32'h0, 2, 1, 32'hCAFEF00D, 0);
        do_frame("unknown", 8'h7F, 32'h0, 32'h0, 0, 1, 32'h0, 0);

        nb0 = n_bus;
        tx_q.delete();
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        tick(BYTE_TO + 10);
        check("stall_idle", {31'h0, busy}, 32'h0);
        check("stall_nbus", n_bus - nb0, 0);
        check("stall_tx", tx_q.size(), 0);
        do_frame("after_stall", 8'h02, 32'h00001234, 32'h0, 0, 2, 32'h0BADF00D, 0);

        for (int k = 0; k < 10; k++) begin
            c = 8'($urandom);
            if ($urandom_range(0, 7) != 0) c = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
            a = $urandom; d = $urandom; r = $urandom;
            do_frame("rand", c, a, d, $urandom_range(0, 3), $urandom_range(1, 4), r, 0);
        end

        check("pre_ovr", {31'h0, overrun}, 32'h0);
        do_frame("ovr", 8'h01, 32'h00000040, 32'hA5A5A5A5, 0, 3, 32'h0, 1);
        check("ovr_sticky", {31'h0, overrun}, 32'h1);

        s_mode = 3;
        send_byte(8'h02);
        send_word(32'h00000080);
        tick(3);
        check("rstmid_cyc_before", {31'h0, wb_cyc_o}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_cyc", {31'h0, wb_cyc_o}, 32'h0);
        check("rstmid_stb", {31'h0, wb_stb_o}, 32'h0);
        check("rstmid_ovr", {31'h0, overrun}, 32'h0);
        check("rstmid_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(2);
        do_frame("post_rst", 8'h01, 32'h00000044, 32'h5A5A0F0F, 0, 1, 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
